// File: rtl/mem_phase_port_pkg.sv
// Shared types for the phase-driven memory port: FSM states, access kinds
// and the phase-vector legality helper.
package mem_phase_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } kind_e;

  function automatic logic phase_legal(input logic [3:0] ph);
    return $onehot(ph);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Request-to-ack cycle counter; expire is high during the TMO-th counted cycle.
module mem_timeout_ctr #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == CW'(TMO - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_phase_port.sv
// Bridges the CPU phase sequencer to a single-outstanding external memory
// port: one fetch, load or store per phase, freezing the sequencer until done.
module mem_phase_port
  import mem_phase_port_pkg::*;
#(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          phase_decode,
  input  logic          phase_exec,
  input  logic          phase_rdmem,
  input  logic          phase_fetch,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] daddr,
  input  logic          ld_req,
  input  logic          st_req,
  input  logic [DW-1:0] st_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          hold,
  output logic [DW-1:0] insn,
  output logic          insn_valid,
  output logic [DW-1:0] ldata,
  output logic          ldata_valid,
  output logic          phase_err,
  output logic          bus_err
);

  state_e state_q, state_d;
  kind_e  kind_q, kind_d, req_kind;

  logic [AW-1:0] mem_addr_q, mem_addr_d, req_addr;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] insn_q, insn_d, ldata_q, ldata_d, result;
  logic          mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic          insn_valid_q, insn_valid_d, ldata_valid_q, ldata_valid_d;
  logic          phase_err_q, phase_err_d, bus_err_q, bus_err_d;

  logic phase_ok, need_fetch, need_st, need_ld, access_needed;
  logic start, ack_hit, tmo_hit, ctr_clr, ctr_en, expire;

  // An illegal phase vector requests nothing, so the FSM cannot leave IDLE.
  assign phase_ok      = phase_legal({phase_decode, phase_exec, phase_rdmem, phase_fetch});
  assign need_fetch    = phase_ok && phase_fetch;
  assign need_st       = phase_ok && phase_rdmem && st_req;
  assign need_ld       = phase_ok && phase_rdmem && ld_req && !st_req;
  assign access_needed = need_fetch || need_st || need_ld;
  assign req_kind      = need_fetch ? FETCH : (need_st ? STORE : LOAD);
  assign req_addr      = need_fetch ? pc : daddr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access_needed) state_d = REQ;
      REQ:     if (mem_ack || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold    = access_needed && (state_q != DONE);
    start   = (state_q == IDLE) && access_needed;
    ack_hit = (state_q == REQ) && mem_ack;
    tmo_hit = (state_q == REQ) && !mem_ack && expire;
    ctr_en  = (state_q == REQ);
    ctr_clr = (state_q != REQ);
  end

  mem_timeout_ctr #(.TMO(TMO)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clr),
    .enable (ctr_en),
    .expire (expire)
  );

  // A timed-out read returns all-ones so software sees a recognisable value.
  assign result = ack_hit ? mem_rdata : {DW{1'b1}};

  always_comb begin
    kind_d        = kind_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_d      = mem_wr_q;
    insn_d        = insn_q;
    ldata_d       = ldata_q;
    insn_valid_d  = 1'b0;
    ldata_valid_d = 1'b0;
    phase_err_d   = !phase_ok;
    bus_err_d     = bus_err_q || tmo_hit;
    if (start) begin
      kind_d      = req_kind;
      mem_addr_d  = req_addr;
      mem_wdata_d = st_data;
      mem_rd_d    = (req_kind != STORE);
      mem_wr_d    = (req_kind == STORE);
    end
    if (ack_hit || tmo_hit) begin
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      if (kind_q == FETCH) begin
        insn_d       = result;
        insn_valid_d = 1'b1;
      end else if (kind_q == LOAD) begin
        ldata_d       = result;
        ldata_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_q        <= FETCH;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      insn_q        <= '0;
      ldata_q       <= '0;
      insn_valid_q  <= 1'b0;
      ldata_valid_q <= 1'b0;
      phase_err_q   <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      kind_q        <= kind_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      insn_q        <= insn_d;
      ldata_q       <= ldata_d;
      insn_valid_q  <= insn_valid_d;
      ldata_valid_q <= ldata_valid_d;
      phase_err_q   <= phase_err_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign insn        = insn_q;
  assign ldata       = ldata_q;
  assign insn_valid  = insn_valid_q;
  assign ldata_valid = ldata_valid_q;
  assign phase_err   = phase_err_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_phase_port.sv
// Directed bench for mem_phase_port: fetch, store, load, priority, timeout,
// illegal phase, stray ack and reset during a request.
module tb_mem_phase_port;

  logic        clk;
  logic        rst;
  logic        phase_decode, phase_exec, phase_rdmem, phase_fetch;
  logic [15:0] pc, daddr, st_data, mem_addr, mem_wdata, mem_rdata;
  logic        ld_req, st_req, mem_rd, mem_wr, mem_ack, hold;
  logic [15:0] insn, ldata;
  logic        insn_valid, ldata_valid, phase_err, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  int          hcnt, rdc, wrc, ivc, lvc, pec;
  logic [15:0] a_seen, w_seen;
  bit          stable, fin;

  mem_phase_port #(.AW(16), .DW(16), .TMO(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .phase_decode (phase_decode),
    .phase_exec   (phase_exec),
    .phase_rdmem  (phase_rdmem),
    .phase_fetch  (phase_fetch),
    .pc           (pc),
    .daddr        (daddr),
    .ld_req       (ld_req),
    .st_req       (st_req),
    .st_data      (st_data),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .hold         (hold),
    .insn         (insn),
    .insn_valid   (insn_valid),
    .ldata        (ldata),
    .ldata_valid  (ldata_valid),
    .phase_err    (phase_err),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_decode();
    phase_decode = 1'b1;
    phase_exec   = 1'b0;
    phase_rdmem  = 1'b0;
    phase_fetch  = 1'b0;
    ld_req       = 1'b0;
    st_req       = 1'b0;
  endtask

  // Runs one phase; ack_at is the request cycle that gets mem_ack (0 = never).
  task automatic do_phase(input bit is_fetch, input logic ld, input logic st,
                          input logic [15:0] a, input logic [15:0] d,
                          input int ack_at, input logic [15:0] rdat);
    @(negedge clk);
    phase_decode = 1'b0;
    phase_exec   = 1'b0;
    phase_fetch  = is_fetch;
    phase_rdmem  = !is_fetch;
    pc = a; daddr = a; ld_req = ld; st_req = st; st_data = d;
    mem_ack = 1'b0;
    hcnt = 0; rdc = 0; wrc = 0; ivc = 0; lvc = 0; stable = 1'b1; fin = 1'b0;
    a_seen = '0; w_seen = '0;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (mem_rd || mem_wr) begin
        if (rdc + wrc == 0) begin
          a_seen = mem_addr;
          w_seen = mem_wdata;
        end else if (mem_addr !== a_seen || mem_wdata !== w_seen) begin
          stable = 1'b0;
        end
        rdc += int'(mem_rd);
        wrc += int'(mem_wr);
        mem_ack   = (rdc + wrc == ack_at);
        mem_rdata = rdat;
      end else begin
        mem_ack = 1'b0;
      end
      if (insn_valid)  ivc++;
      if (ldata_valid) lvc++;
      if (hold) hcnt++;
      else fin = 1'b1;
    end
    if (!fin) chk("phase_completes", 0, 1);
    @(negedge clk);
    set_decode();
    mem_ack = 1'b0;
    #1;
    if (insn_valid)  ivc++;
    if (ldata_valid) lvc++;
  endtask

  initial begin
    rst = 1'b0;
    set_decode();
    pc = '0; daddr = '0; st_data = '0; mem_rdata = '0; mem_ack = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_insn", insn, 0);
    chk("rst_ldata", ldata, 0);
    chk("rst_strobes", {insn_valid, ldata_valid, phase_err}, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_hold", hold, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fetch, ack on the second read cycle.
    do_phase(1'b1, 1'b0, 1'b0, 16'h0123, 16'h0000, 2, 16'hBEEF);
    chk("fetch_hold_cycles", hcnt, 3);
    chk("fetch_rd_cycles", rdc, 2);
    chk("fetch_wr_cycles", wrc, 0);
    chk("fetch_addr", a_seen, 16'h0123);
    chk("fetch_stable", stable, 1);
    chk("fetch_insn", insn, 16'hBEEF);
    chk("fetch_insn_valid_pulses", ivc, 1);
    chk("fetch_ldata_valid_pulses", lvc, 0);

    // Store, immediate ack.
    do_phase(1'b0, 1'b0, 1'b1, 16'h0040, 16'h5A5A, 1, 16'h0000);
    chk("store_hold_cycles", hcnt, 2);
    chk("store_wr_cycles", wrc, 1);
    chk("store_rd_cycles", rdc, 0);
    chk("store_addr", a_seen, 16'h0040);
    chk("store_wdata", w_seen, 16'h5A5A);
    chk("store_no_valid", ivc + lvc, 0);

    // Load, immediate ack.
    do_phase(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 1, 16'h1234);
    chk("load_rd_cycles", rdc, 1);
    chk("load_addr", a_seen, 16'h0080);
    chk("load_ldata", ldata, 16'h1234);
    chk("load_valid_pulses", lvc, 1);
    chk("load_insn_kept", insn, 16'hBEEF);

    // Load and store together: store wins.
    do_phase(1'b0, 1'b1, 1'b1, 16'h0090, 16'hA5A5, 1, 16'h7777);
    chk("both_wr_cycles", wrc, 1);
    chk("both_rd_cycles", rdc, 0);
    chk("both_wdata", w_seen, 16'hA5A5);
    chk("both_ldata_kept", ldata, 16'h1234);
    chk("both_no_valid", ivc + lvc, 0);

    // Load with no ack: timeout after 15 request cycles.
    do_phase(1'b0, 1'b1, 1'b0, 16'h00A0, 16'h0000, 0, 16'h0000);
    chk("tmo_rd_cycles", rdc, 15);
    chk("tmo_hold_cycles", hcnt, 16);
    chk("tmo_ldata", ldata, 16'hFFFF);
    chk("tmo_valid_pulses", lvc, 1);
    chk("tmo_bus_err", bus_err, 1);

    // Sticky bus_err across a good fetch.
    do_phase(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1, 16'h4321);
    chk("sticky_insn", insn, 16'h4321);
    chk("sticky_bus_err", bus_err, 1);

    // Illegal phase vector: exec and fetch together.
    @(negedge clk);
    phase_decode = 1'b0; phase_exec = 1'b1; phase_fetch = 1'b1; pc = 16'h0300;
    #1;
    chk("perr_hold", hold, 0);
    pec = 0;
    @(negedge clk);
    set_decode();
    for (int c = 0; c < 3; c++) begin
      #1;
      if (phase_err) pec++;
      if (mem_rd || mem_wr) pec += 100;
      @(negedge clk);
    end
    chk("perr_pulses", pec, 1);

    // Stray ack while idle.
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_valid", {insn_valid, ldata_valid}, 0);
    chk("stray_insn", insn, 16'h4321);
    chk("stray_ldata", ldata, 16'hFFFF);
    chk("stray_rd", {mem_rd, mem_wr}, 0);

    // Reset asserted while a fetch is in REQ.
    @(negedge clk);
    phase_decode = 1'b0; phase_fetch = 1'b1; pc = 16'h0200; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("rstreq_pre_rd", mem_rd, 1);
    rst = 1'b0;
    #1;
    chk("rstreq_rd_dropped", mem_rd, 0);
    chk("rstreq_addr", mem_addr, 0);
    chk("rstreq_bus_err", bus_err, 0);
    @(negedge clk);
    set_decode();
    rst = 1'b1;
    do_phase(1'b1, 1'b0, 1'b0, 16'h0204, 16'h0000, 1, 16'hCAFE);
    chk("rstreq_fetch_hold", hcnt, 2);
    chk("rstreq_fetch_addr", a_seen, 16'h0204);
    chk("rstreq_fetch_insn", insn, 16'hCAFE);
    chk("rstreq_fetch_valid", ivc, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
